// File: rtl/glorb_pkg.sv
// Shared definitions for the glorb core: instruction layout, opcodes and FSM states.
package glorb_pkg;

    localparam int INSTR_W = 16;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_LI   = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_BEQ  = 4'd9,
        OP_BNE  = 4'd10,
        OP_JMP  = 4'd11,
        OP_OUT  = 4'd12,
        OP_HALT = 4'd13,
        OP_MUL  = 4'd14,
        OP_ILL  = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/glorb_regfile.sv
// NREGS x DATA_W register file: two asynchronous read ports, one write port.
// r0 is never written, so it always reads back as zero.
module glorb_regfile import glorb_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [IDX_W-1:0]  raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    // Storage: cleared on reset, writes to r0 dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/glorb_core.sv
// glorb_core: multi-cycle FETCH/EXEC/WB core with register file, branches, OUT port and HALT.
// Optional multiplier for opcode 14 enabled by defining GLORB_CORE_MUL_EN.
module glorb_core import glorb_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 4,
    parameter int NREGS  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);

    localparam int RIDX_W = $clog2(NREGS);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q;
    logic [INSTR_W-1:0]  ir_q;
    logic [DATA_W-1:0]   alu_q;
    logic [PC_W-1:0]     next_pc_q;
    logic                wr_en_q;
    logic                out_en_q;
    logic [DATA_W-1:0]   dout_q;
    logic                dout_valid_q;
    logic                illegal_q;

    opcode_t             op;
    logic [RIDX_W-1:0]   rd_idx, rs1_idx, rs2_idx;
    logic [7:0]          imm8;
    logic [3:0]          br_off;
    logic [DATA_W-1:0]   rs1_val, rs2_val;
    logic [PC_W-1:0]     pc_inc;

    logic [DATA_W-1:0]   alu_d;
    logic [PC_W-1:0]     next_pc_d;
    logic                wr_en_d;
    logic                out_en_d;
    logic                ill_d;

    assign op      = opcode_t'(ir_q[OP_MSB:OP_LSB]);
    assign rd_idx  = ir_q[RD_LSB +: RIDX_W];
    assign rs1_idx = ir_q[RS1_LSB +: RIDX_W];
    assign rs2_idx = ir_q[RS2_LSB +: RIDX_W];
    assign imm8    = ir_q[IMM_MSB:IMM_LSB];
    assign br_off  = ir_q[RD_MSB:RD_LSB];
    assign pc_inc  = pc_q + PC_W'(1);

    glorb_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .IDX_W  (RIDX_W)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     ((state_q == ST_WB) && wr_en_q),
        .waddr  (rd_idx),
        .wdata  (alu_q),
        .raddr1 (rs1_idx),
        .rdata1 (rs1_val),
        .raddr2 (rs2_idx),
        .rdata2 (rs2_val)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only honoured in IDLE, HALT is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WB;
            ST_WB:    state_d = (op == OP_HALT) ? ST_HALT : ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ALU, branch compare and next-PC selection for the instruction held in IR.
    always_comb begin
        alu_d     = '0;
        next_pc_d = pc_inc;
        wr_en_d   = 1'b0;
        out_en_d  = 1'b0;
        ill_d     = 1'b0;
        case (op)
            OP_ADD: begin alu_d = rs1_val + rs2_val; wr_en_d = 1'b1; end
            OP_SUB: begin alu_d = rs1_val - rs2_val; wr_en_d = 1'b1; end
            OP_AND: begin alu_d = rs1_val & rs2_val; wr_en_d = 1'b1; end
            OP_OR:  begin alu_d = rs1_val | rs2_val; wr_en_d = 1'b1; end
            OP_XOR: begin alu_d = rs1_val ^ rs2_val; wr_en_d = 1'b1; end
            OP_LI:  begin alu_d = DATA_W'(imm8);     wr_en_d = 1'b1; end
            OP_SHL: begin alu_d = rs1_val << 1;      wr_en_d = 1'b1; end
            OP_SHR: begin alu_d = rs1_val >> 1;      wr_en_d = 1'b1; end
            OP_BEQ: begin
                if (rs1_val == rs2_val) next_pc_d = pc_inc + PC_W'(signed'(br_off));
            end
            OP_BNE: begin
                if (rs1_val != rs2_val) next_pc_d = pc_inc + PC_W'(signed'(br_off));
            end
            OP_JMP: next_pc_d = PC_W'(imm8);
            OP_OUT: begin alu_d = rs1_val; out_en_d = 1'b1; end
`ifdef GLORB_CORE_MUL_EN
            OP_MUL: begin alu_d = rs1_val * rs2_val; wr_en_d = 1'b1; end
`else
            OP_MUL: ill_d = 1'b1;
`endif
            OP_ILL: ill_d = 1'b1;
            default: ;
        endcase
    end

    // FETCH latches the instruction word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else if (state_q == ST_FETCH) begin
            ir_q <= imem_data;
        end
    end

    // EXEC registers the result, the resolved next PC and the writeback controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q     <= '0;
            next_pc_q <= '0;
            wr_en_q   <= 1'b0;
            out_en_q  <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            alu_q     <= alu_d;
            next_pc_q <= next_pc_d;
            wr_en_q   <= wr_en_d;
            out_en_q  <= out_en_d;
        end
    end

    // Sticky flag for undefined opcodes, raised when one reaches EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if ((state_q == ST_EXEC) && ill_d) begin
            illegal_q <= 1'b1;
        end
    end

    // WB commits the PC and drives the output port; dout holds between OUTs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= (state_q == ST_WB) && out_en_q;
            if (state_q == ST_WB) begin
                pc_q <= next_pc_q;
                if (out_en_q) dout_q <= alu_q;
            end
        end
    end

    assign imem_addr  = pc_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign illegal    = illegal_q;
    assign busy       = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_WB);
    assign halted     = (state_q == ST_HALT);

endmodule
